// File: rtl/freq_histogram_if.sv
// Symbol-in, clear-control and readback signals of the frequency histogram.
// The master drives symbols, clear and read requests; the slave is the histogram itself.
interface freq_histogram_if #(
  parameter int unsigned SYM_W = 8,
  parameter int unsigned CNT_W = 24,
  parameter int unsigned TOT_W = 32
);
  logic             in_valid;
  logic [SYM_W-1:0] in_sym;
  logic             in_ready;
  logic             clear_req;
  logic             busy;
  logic             rd_en;
  logic [SYM_W-1:0] rd_addr;
  logic             rd_valid;
  logic [CNT_W-1:0] rd_data;
  logic [TOT_W-1:0] total;
  logic             sat_any;

  modport master (
    output in_valid, in_sym, clear_req, rd_en, rd_addr,
    input  in_ready, busy, rd_valid, rd_data, total, sat_any
  );

  modport slave (
    input  in_valid, in_sym, clear_req, rd_en, rd_addr,
    output in_ready, busy, rd_valid, rd_data, total, sat_any
  );
endinterface

// File: rtl/freq_histogram.sv
// Saturating symbol-frequency histogram: one symbol per cycle through a two-stage
// read-modify-write pipeline, with a swept clear, running total and registered readback.
module freq_histogram #(
  parameter int unsigned SYM_W = 8,
  parameter int unsigned CNT_W = 24,
  parameter int unsigned TOT_W = 32
) (
  input logic             clk,
  input logic             reset_n,
  freq_histogram_if.slave bus_io
);

  localparam int unsigned NumBins = 1 << SYM_W;
  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [TOT_W-1:0] TotMax = '1;

  typedef enum logic [0:0] {StClear, StRun} state_e;

  state_e           state_q;
  logic [SYM_W-1:0] sweep_idx_q;
  logic [CNT_W-1:0] mem_q [NumBins];

  logic             s1_valid_q;
  logic [SYM_W-1:0] s1_sym_q;
  logic [CNT_W-1:0] s1_old_q;
  logic [TOT_W-1:0] total_q;
  logic             sat_any_q;
  logic             rd_valid_q;
  logic [CNT_W-1:0] rd_data_q;

  logic             in_ready;
  logic             accept;
  logic [CNT_W-1:0] s1_new;
  logic [CNT_W-1:0] s0_old;

  always_comb begin
    in_ready = (state_q == StRun) && !bus_io.clear_req;
    accept   = bus_io.in_valid && in_ready;
    s1_new   = (s1_old_q == CntMax) ? s1_old_q : s1_old_q + CNT_W'(1);
    // Same symbol still in stage 1: its write has not landed yet, take the fresh result.
    s0_old   = (s1_valid_q && (s1_sym_q == bus_io.in_sym)) ? s1_new : mem_q[bus_io.in_sym];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StClear;
      sweep_idx_q <= '0;
      s1_valid_q  <= 1'b0;
      s1_sym_q    <= '0;
      s1_old_q    <= '0;
      total_q     <= '0;
      sat_any_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      rd_valid_q <= bus_io.rd_en;
      if (bus_io.rd_en) begin
        rd_data_q <= mem_q[bus_io.rd_addr];
      end
      s1_valid_q <= accept;
      if (accept) begin
        s1_sym_q <= bus_io.in_sym;
        s1_old_q <= s0_old;
      end
      unique case (state_q)
        StClear: begin
          if (sweep_idx_q == '1) begin
            state_q     <= StRun;
            sweep_idx_q <= '0;
          end else begin
            sweep_idx_q <= sweep_idx_q + SYM_W'(1);
          end
        end
        StRun: begin
          if (bus_io.clear_req) begin
            state_q   <= StClear;
            total_q   <= '0;
            sat_any_q <= 1'b0;
          end else begin
            if (accept && (total_q != TotMax)) begin
              total_q <= total_q + TOT_W'(1);
            end
            if (s1_valid_q && (s1_old_q == CntMax - CNT_W'(1))) begin
              sat_any_q <= 1'b1;
            end
          end
        end
        default: state_q <= StClear;
      endcase
    end
  end

  // Table has no reset; the sweep initialises it and wins over any stage-1 write.
  always_ff @(posedge clk) begin
    if (state_q == StClear) begin
      mem_q[sweep_idx_q] <= '0;
    end else if (s1_valid_q) begin
      mem_q[s1_sym_q] <= s1_new;
    end
  end

  assign bus_io.in_ready = in_ready;
  assign bus_io.busy     = (state_q == StClear);
  assign bus_io.rd_valid = rd_valid_q;
  assign bus_io.rd_data  = rd_data_q;
  assign bus_io.total    = total_q;
  assign bus_io.sat_any  = sat_any_q;

endmodule

// File: tb/tb_freq_histogram.sv
// Self-checking bench for freq_histogram: a wide-counter instance and a 4-bit-counter
// instance, random and directed streams compared against a per-bin counting model.
module tb_freq_histogram;

  localparam longint unsigned MainMax = (64'd1 << 24) - 1;
  localparam longint unsigned SatMax  = 15;
  localparam longint unsigned TotMax  = (64'd1 << 32) - 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  freq_histogram_if #(.SYM_W(8), .CNT_W(24), .TOT_W(32)) hb ();
  freq_histogram_if #(.SYM_W(8), .CNT_W(4), .TOT_W(32)) hs ();

  freq_histogram #(.SYM_W(8), .CNT_W(24), .TOT_W(32)) u_dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus_io (hb)
  );

  freq_histogram #(.SYM_W(8), .CNT_W(4), .TOT_W(32)) u_dut_sat (
    .clk    (clk),
    .reset_n(reset_n),
    .bus_io (hs)
  );

  int unsigned      n_checks = 0;
  int unsigned      n_errors = 0;
  longint unsigned  model_bin [256];
  longint unsigned  model_tot;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 256; i++) model_bin[i] = 0;
    model_tot = 0;
  endtask

  task automatic model_accept(input int unsigned s);
    if (model_bin[s] < MainMax) model_bin[s] = model_bin[s] + 1;
    if (model_tot < TotMax) model_tot = model_tot + 1;
  endtask

  // Streams one symbol per cycle into the main instance; the caller knows it is running.
  task automatic send(input int unsigned s);
    hb.in_valid = 1'b1;
    hb.in_sym   = 8'(s);
    model_accept(s);
    tick();
  endtask

  task automatic drain();
    hb.in_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic read_main(input int unsigned a, output logic [23:0] d);
    hb.rd_en   = 1'b1;
    hb.rd_addr = 8'(a);
    tick();
    hb.rd_en = 1'b0;
    d = hb.rd_data;
  endtask

  task automatic read_all(input string tag);
    logic [23:0] d;
    for (int i = 0; i < 256; i++) begin
      read_main(i, d);
      check_eq($sformatf("%s[%0d]", tag, i), 64'(d), model_bin[i]);
    end
  endtask

  // Counts cycles until the sweep ends, optionally re-pulsing clear part-way through.
  task automatic wait_run(input bit pulse_mid, output int cycles);
    cycles = 0;
    while (hb.busy && cycles < 400) begin
      hb.clear_req = pulse_mid && (cycles == 100);
      tick();
      cycles++;
    end
    hb.clear_req = 1'b0;
    hb.in_valid  = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_in_ready"}, 64'(hb.in_ready), 64'd0);
    check_eq({tag, "_busy"},     64'(hb.busy),     64'd1);
    check_eq({tag, "_rd_valid"}, 64'(hb.rd_valid), 64'd0);
    check_eq({tag, "_rd_data"},  64'(hb.rd_data),  64'd0);
    check_eq({tag, "_total"},    64'(hb.total),    64'd0);
    check_eq({tag, "_sat_any"},  64'(hb.sat_any),  64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cycles;
    logic [23:0] d;
    longint unsigned m;
    longint unsigned sat_bin;
    longint unsigned sat_tot;

    hb.in_valid = 1'b1; hb.in_sym = 8'h00; hb.clear_req = 1'b0;
    hb.rd_en = 1'b0; hb.rd_addr = 8'h00;
    hs.in_valid = 1'b0; hs.in_sym = 8'h00; hs.clear_req = 1'b0;
    hs.rd_en = 1'b0; hs.rd_addr = 8'h00;
    model_clear();

    // Reset values and the power-up sweep with in_valid held high.
    repeat (3) tick();
    check_reset_vals("rst");
    reset_n = 1'b1;
    wait_run(1'b0, cycles);
    check_eq("pwrup_sweep_cycles", 64'(cycles), 64'd256);
    check_eq("pwrup_in_ready", 64'(hb.in_ready), 64'd1);
    check_eq("pwrup_total", 64'(hb.total), 64'd0);
    read_all("pwrup_bin");

    // Short directed stream.
    send(8'h00); send(8'h01); send(8'h01); send(8'h02); send(8'h02); send(8'h02);
    check_eq("short_total_on_accept", 64'(hb.total), 64'd6);
    drain();
    for (int i = 0; i < 3; i++) begin
      read_main(i, d);
      check_eq($sformatf("short_bin%0d", i), 64'(d), model_bin[i]);
    end
    check_eq("short_rd_valid", 64'(hb.rd_valid), 64'd1);
    tick();
    check_eq("short_rd_valid_drop", 64'(hb.rd_valid), 64'd0);

    // Clear, then a long run of one symbol through the forwarding path.
    hb.clear_req = 1'b1;
    tick();
    hb.clear_req = 1'b0;
    model_clear();
    wait_run(1'b0, cycles);
    for (int i = 0; i < 1000; i++) send(8'h41);
    drain();
    check_eq("fwd_total", 64'(hb.total), 64'd1000);
    read_main(8'h41, d);
    check_eq("fwd_bin41", 64'(d), 64'd1000);
    read_all("fwd_bin");
    check_eq("fwd_sat_any", 64'(hb.sat_any), 64'd0);

    // Random stream with gaps over a small alphabet, plus occasional wide symbols.
    for (int i = 0; i < 600; i++) begin
      int unsigned s;
      bit v;
      v = ($urandom_range(0, 9) < 7);
      s = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 7);
      hb.in_valid = v;
      hb.in_sym   = 8'(s);
      if (v) model_accept(s);
      tick();
    end
    drain();
    check_eq("rand_total", 64'(hb.total), model_tot);
    read_all("rand_bin");

    // Read racing an accept and the following write-back.
    m = model_bin[5];
    hb.in_valid = 1'b1; hb.in_sym = 8'h05; hb.rd_en = 1'b1; hb.rd_addr = 8'h05;
    tick();
    model_accept(5);
    hb.in_valid = 1'b0;
    check_eq("race_pre_incr", 64'(hb.rd_data), m);
    tick();
    check_eq("race_write_edge", 64'(hb.rd_data), m);
    tick();
    hb.rd_en = 1'b0;
    check_eq("race_after_write", 64'(hb.rd_data), m + 1);

    // Clear with a symbol offered; a second clear mid-sweep must not extend it.
    send(8'h10); send(8'h11);
    hb.in_valid = 1'b1; hb.in_sym = 8'h12; hb.clear_req = 1'b1;
    #1;
    check_eq("clr_in_ready_blocked", 64'(hb.in_ready), 64'd0);
    tick();
    hb.clear_req = 1'b0;
    model_clear();
    check_eq("clr_busy", 64'(hb.busy), 64'd1);
    check_eq("clr_total", 64'(hb.total), 64'd0);
    wait_run(1'b1, cycles);
    check_eq("clr_sweep_cycles", 64'(cycles), 64'd256);
    check_eq("clr_total_after", 64'(hb.total), 64'd0);
    read_all("clr_bin");

    // Narrow-counter instance: saturation and sticky flag.
    sat_bin = 0;
    sat_tot = 0;
    for (int i = 0; i < 20; i++) begin
      hs.in_valid = 1'b1;
      hs.in_sym   = 8'h07;
      if (sat_bin < SatMax) sat_bin++;
      sat_tot++;
      tick();
      if (i == 13 || i == 14) begin
        hs.in_valid = 1'b0;
        tick();
        tick();
        check_eq($sformatf("sat_flag_after_%0d", i + 1), 64'(hs.sat_any),
                 (sat_bin == SatMax) ? 64'd1 : 64'd0);
      end
    end
    hs.in_valid = 1'b0;
    tick();
    tick();
    hs.rd_en = 1'b1; hs.rd_addr = 8'h07;
    tick();
    hs.rd_en = 1'b0;
    check_eq("sat_bin7", 64'(hs.rd_data), sat_bin);
    check_eq("sat_total", 64'(hs.total), sat_tot);
    check_eq("sat_flag", 64'(hs.sat_any), 64'd1);
    hs.clear_req = 1'b1;
    tick();
    hs.clear_req = 1'b0;
    check_eq("sat_flag_cleared", 64'(hs.sat_any), 64'd0);
    check_eq("sat_total_cleared", 64'(hs.total), 64'd0);
    repeat (260) tick();

    // Asynchronous reset in the middle of a stream with a read pending.
    for (int i = 0; i < 20; i++) send($urandom_range(0, 255));
    hb.rd_en = 1'b1; hb.rd_addr = 8'h03;
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    hb.in_valid = 1'b1;
    hb.rd_en    = 1'b0;
    tick();
    model_clear();
    reset_n = 1'b1;
    wait_run(1'b0, cycles);
    check_eq("rerun_sweep_cycles", 64'(cycles), 64'd256);
    check_eq("rerun_total", 64'(hb.total), 64'd0);
    read_all("rerun_bin");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
